// File: rtl/irq_encoder_8_3_pkg.sv
// Shared widths and FSM encoding for the 8-to-3 interrupt request encoder.
// IRQ_ENC_ROUND_ROBIN_EN selects round-robin instead of lowest-index priority.
package irq_enc_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;
endpackage

// File: rtl/irq_encoder_8_3_if.sv
// Request/grant bundle between request sources, the encoder and the control unit.
interface irq_encoder_8_3_if
  import irq_enc_pkg::*;
();
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  mask;
  logic              en;
  logic              ack;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic [N_REQ-1:0]  pending;

  modport master (output req, mask, en, ack, input code, valid, pending);
  modport slave  (input req, mask, en, ack, output code, valid, pending);
endinterface

// File: rtl/irq_encoder_8_3_prio_find_8.sv
// Combinational search for the first set candidate bit at or after start, wrapping at 8.
module prio_find_8
  import irq_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  cand,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              any
);
  logic [CODE_W-1:0] pos_s;

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    idx   = {CODE_W{1'b0}};
    any   = 1'b0;
    pos_s = {CODE_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos_s = start + CODE_W'(i);
      if (cand[pos_s]) begin
        idx = pos_s;
        any = 1'b1;
      end else begin
        idx = idx;
        any = any;
      end
    end
  end
endmodule

// File: rtl/irq_encoder_8_3.sv
// Captures request lines into a pending register and presents one eligible index
// with a valid/ack handshake. Optional macro: IRQ_ENC_ROUND_ROBIN_EN.
module irq_encoder_8_3 #(
  parameter int N_REQ  = 8,
  parameter int CODE_W = 3,
  parameter int EDGE   = 1
) (
  input logic             clk,
  input logic             rst_n,
  irq_encoder_8_3_if.slave bus
);
  import irq_enc_pkg::*;

  state_t            state_r, state_n;
  logic [CODE_W-1:0] code_r, code_n, idx_s, start_s;
  logic              valid_r, valid_n, any_s;
  logic [N_REQ-1:0]  pending_r, pending_n, req_d_r, set_s, clr_s, cand_s;

  // Capture and clear of pending bits; a coincident set keeps the bit pending.
  always_comb begin
    set_s = (EDGE != 0) ? (bus.req & ~req_d_r) : bus.req;
    clr_s = {N_REQ{1'b0}};
    if ((state_r == PRESENT) && bus.ack) begin
      clr_s[code_r] = 1'b1;
    end else begin
      clr_s = {N_REQ{1'b0}};
    end
    pending_n = set_s | (pending_r & ~clr_s);
    cand_s    = pending_r & ~bus.mask;
  end

`ifdef IRQ_ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] rr_ptr_r;

  // Last serviced index; the search starts just after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {CODE_W{1'b1}};
    end else if ((state_r == PRESENT) && bus.ack) begin
      rr_ptr_r <= code_r;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign start_s = rr_ptr_r + CODE_W'(1);
`else
  assign start_s = {CODE_W{1'b0}};
`endif

  prio_find_8 u_prio (
    .cand  (cand_s),
    .start (start_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  // Grant FSM: code/valid are frozen while presenting, whatever mask or en do.
  always_comb begin
    state_n = state_r;
    code_n  = code_r;
    valid_n = valid_r;
    case (state_r)
      IDLE: begin
        if (bus.en && any_s) begin
          code_n  = idx_s;
          valid_n = 1'b1;
          state_n = PRESENT;
        end else begin
          valid_n = 1'b0;
        end
      end
      PRESENT: begin
        if (bus.ack) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end else begin
          valid_n = 1'b1;
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      code_r    <= {CODE_W{1'b0}};
      valid_r   <= 1'b0;
      pending_r <= {N_REQ{1'b0}};
      req_d_r   <= {N_REQ{1'b0}};
    end else begin
      state_r   <= state_n;
      code_r    <= code_n;
      valid_r   <= valid_n;
      pending_r <= pending_n;
      req_d_r   <= bus.req;
    end
  end

  assign bus.code    = code_r;
  assign bus.valid   = valid_r;
  assign bus.pending = pending_r;
endmodule

// File: tb/tb_irq_encoder_8_3.sv
// Directed table-driven bench for irq_encoder_8_3 (edge and level capture instances).
module tb_irq_encoder_8_3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  irq_encoder_8_3_if bus ();
  irq_encoder_8_3_if bus2 ();

  irq_encoder_8_3 #(.EDGE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  irq_encoder_8_3 #(.EDGE(0)) dut_lvl (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       en;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
  } vec_t;

  vec_t vecs [36];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] c, input logic v,
                           input logic [7:0] p, input logic [2:0] ec, input logic ev,
                           input logic [7:0] ep);
    check({tag, " code"}, {5'd0, c}, {5'd0, ec});
    check({tag, " valid"}, {7'd0, v}, {7'd0, ev});
    check({tag, " pending"}, p, ep);
  endtask

  initial begin
    // req mask en ack | code valid pending
    vecs[0]  = '{8'h20, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h20};
    vecs[1]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 1'b1, 8'h20};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 8'h00};
    vecs[3]  = '{8'h90, 8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 8'h90};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 8'h90};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd4, 1'b0, 8'h80};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 8'h80};
    vecs[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 1'b0, 8'h00};
    vecs[8]  = '{8'h11, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 8'h11};
    vecs[9]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h11};
    vecs[10] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h10};
    vecs[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 8'h10};
    vecs[12] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd4, 1'b0, 8'h00};
    vecs[13] = '{8'h03, 8'h01, 1'b1, 1'b0, 3'd4, 1'b0, 8'h03};
    vecs[14] = '{8'h00, 8'h01, 1'b1, 1'b0, 3'd1, 1'b1, 8'h03};
    vecs[15] = '{8'h00, 8'h01, 1'b1, 1'b1, 3'd1, 1'b0, 8'h01};
    vecs[16] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h01};
    vecs[17] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00};
    vecs[18] = '{8'h04, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04};
    vecs[19] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04};
    vecs[20] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04};
    vecs[21] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h04};
    vecs[22] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00};
    vecs[23] = '{8'h40, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 8'h40};
    vecs[24] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd6, 1'b1, 8'h40};
    vecs[25] = '{8'h01, 8'hFF, 1'b1, 1'b0, 3'd6, 1'b1, 8'h41};
    vecs[26] = '{8'h01, 8'hFF, 1'b0, 1'b0, 3'd6, 1'b1, 8'h41};
    vecs[27] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd6, 1'b0, 8'h01};
    vecs[28] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h01};
    vecs[29] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00};
    vecs[30] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00};
    vecs[31] = '{8'h08, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h08};
    vecs[32] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h08};
    vecs[33] = '{8'h08, 8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 8'h08};
    vecs[34] = '{8'h08, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h08};
    vecs[35] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 8'h00};

    bus.req = 8'h00;  bus.mask = 8'h00;  bus.en = 1'b1;  bus.ack = 1'b0;
    bus2.req = 8'h00; bus2.mask = 8'h00; bus2.en = 1'b1; bus2.ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("idle%0d", i), bus.code, bus.valid, bus.pending, 3'd0, 1'b0, 8'h00);
    end

    // Asynchronous reset while a grant is presented.
    bus.req = 8'h20;
    tick();
    bus.req = 8'h00;
    tick();
    check_out("pre_rst", bus.code, bus.valid, bus.pending, 3'd5, 1'b1, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", bus.code, bus.valid, bus.pending, 3'd0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      bus.req  = vecs[i].req;
      bus.mask = vecs[i].mask;
      bus.en   = vecs[i].en;
      bus.ack  = vecs[i].ack;
      tick();
      check_out($sformatf("v%0d", i), bus.code, bus.valid, bus.pending,
                vecs[i].code, vecs[i].valid, vecs[i].pending);
    end
    bus.ack = 1'b0;

    // Level capture: a held request re-pends on its own ack edge.
    bus2.req = 8'h02;
    tick();
    check_out("lvl0", bus2.code, bus2.valid, bus2.pending, 3'd0, 1'b0, 8'h02);
    tick();
    check_out("lvl1", bus2.code, bus2.valid, bus2.pending, 3'd1, 1'b1, 8'h02);
    bus2.ack = 1'b1;
    tick();
    check_out("lvl2", bus2.code, bus2.valid, bus2.pending, 3'd1, 1'b0, 8'h02);
    bus2.ack = 1'b0;
    tick();
    check_out("lvl3", bus2.code, bus2.valid, bus2.pending, 3'd1, 1'b1, 8'h02);
    bus2.req = 8'h00;
    bus2.ack = 1'b1;
    tick();
    check_out("lvl4", bus2.code, bus2.valid, bus2.pending, 3'd1, 1'b0, 8'h00);
    bus2.ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
